// File: rtl/rr_arb_mux.sv
// N:1 streaming multiplexer with selectable round-robin / fixed-priority arbitration
// and a single registered output stage (valid/ready on both sides).
module rr_arb_mux #(
    parameter  int NCH   = 4,
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rr_en,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CW-1:0]        out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] data_q,  data_d;
    logic [CW-1:0]    ch_q,    ch_d;
    logic [CW-1:0]    last_q,  last_d;
    logic             valid_q, valid_d;

    logic             load;
    logic             xfer;
    logic             gnt_any;
    logic [CW-1:0]    gnt_idx;
    logic [NCH-1:0]   grant;
    logic [WIDTH-1:0] gnt_data;

    // Round-robin search starts just after the last granted channel and wraps.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        grant   = '0;
        if (rr_en) begin
            for (int k = 1; k <= NCH; k++) begin
                idx = int'(last_q) + k;
                if (idx >= NCH) idx = idx - NCH;
                if (!gnt_any && in_valid[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = CW'(idx);
                end
            end
        end else begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = CW'(i);
                end
            end
        end
        if (gnt_any) grant[gnt_idx] = 1'b1;
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) gnt_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign load     = !valid_q || out_ready;
    assign xfer     = !rst && load && gnt_any;
    assign in_ready = {NCH{xfer}} & grant;

    always_comb begin
        data_d  = data_q;
        ch_d    = ch_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (xfer) begin
            data_d  = gnt_data;
            ch_d    = gnt_idx;
            last_d  = gnt_idx;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Reset discards any held word and gives channel 0 top round-robin priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            ch_q    <= '0;
            last_q  <= CW'(NCH - 1);
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;

endmodule
